// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter sharing one DMA channel among the endpoint
// register files, with a per-grant burst limit.
module usbf_dma_arb #(
  parameter int EP_CNT    = 4,
  parameter int SEL_W     = 2,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EP_CNT-1:0] ep_dma_req,
  input  logic [EP_CNT-1:0] ep_en,
  output logic [EP_CNT-1:0] ep_dma_ack,
  output logic              dma_req,
  output logic [SEL_W-1:0]  dma_sel,
  output logic              dma_last,
  input  logic              dma_ack,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [EP_CNT-1:0]   vreq;
  logic [2*EP_CNT-1:0] rot;
  logic [SEL_W:0]      sum;
  logic [SEL_W-1:0]    pick;
  logic [SEL_W-1:0]    nxt_ptr;
  logic                found;

  assign vreq = ep_dma_req & ep_en;

  // Rotate so bit 0 is ptr, take the first set bit, map back mod EP_CNT.
  always_comb begin
    rot   = {vreq, vreq} >> ptr_q;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < EP_CNT; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (SEL_W+1)'(i);
        if (sum >= (SEL_W+1)'(EP_CNT))
          sum = sum - (SEL_W+1)'(EP_CNT);
        pick  = sum[SEL_W-1:0];
      end
    end
  end

  assign nxt_ptr = (sel_q == SEL_W'(EP_CNT-1)) ?
                   '0 : sel_q + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dma_ack) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (vreq[sel_q] && cnt_q < 8'(BURST_LEN)) begin
          state_d = BUSY;
        end else begin
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An ack arriving with reset is dropped along with the grant.
  always_comb begin
    dma_req    = (state_q == BUSY);
    busy       = (state_q != IDLE);
    dma_sel    = sel_q;
    dma_last   = dma_req && (cnt_q == 8'(BURST_LEN-1));
    ep_dma_ack = '0;
    if (dma_ack && dma_req && !rst)
      ep_dma_ack[sel_q] = 1'b1;
  end

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Self-checking bench for usbf_dma_arb: four endpoints, two-beat bursts.
// Expected grants are queued as stimulus is applied and popped per beat.
module tb_usbf_dma_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ep_dma_req;
  logic [3:0] ep_en;
  logic [3:0] ep_dma_ack;
  logic       dma_req;
  logic [1:0] dma_sel;
  logic       dma_last;
  logic       dma_ack;
  logic       busy;

  int cmp = 0;
  int err = 0;
  int exp_q[$];

  usbf_dma_arb #(
    .EP_CNT(4),
    .SEL_W(2),
    .BURST_LEN(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ep_dma_req(ep_dma_req),
    .ep_en(ep_en),
    .ep_dma_ack(ep_dma_ack),
    .dma_req(dma_req),
    .dma_sel(dma_sel),
    .dma_last(dma_last),
    .dma_ack(dma_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    ep_dma_req = '0;
    ep_en      = '0;
    dma_ack    = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dma_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    ep_dma_req = 4'hF;
    ep_en      = 4'hF;
    dma_ack    = 1'b0;
    step();
    step();
    cmp++;
    if (dma_req !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_req: req=%b busy=%b want 0 0",
               dma_req, busy);
      err++;
    end
    cmp++;
    if (dma_sel !== 2'd0 || dma_last !== 1'b0) begin
      $display("FAIL reset_sel: sel=%0d last=%b want 0 0",
               dma_sel, dma_last);
      err++;
    end
    cmp++;
    if (ep_dma_ack !== 4'b0) begin
      $display("FAIL reset_ack: got %b want 0000", ep_dma_ack);
      err++;
    end
    ep_dma_req = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single;
    int e;
    do_reset();
    ep_dma_req = 4'b0100;
    ep_en      = 4'hF;
    exp_q.push_back(2);
    step();
    e = exp_q.pop_front();
    cmp++;
    if (dma_req !== 1'b1 || dma_sel !== 2'(e)) begin
      $display("FAIL single_grant: req=%b sel=%0d want 1 %0d",
               dma_req, dma_sel, e);
      err++;
    end
    dma_ack = 1'b1;
    #1;
    cmp++;
    if (ep_dma_ack !== 4'b0100) begin
      $display("FAIL single_ack: got %b want 0100", ep_dma_ack);
      err++;
    end
    step();
    dma_ack    = 1'b0;
    ep_dma_req = '0;
    step();
    step();
    cmp++;
    if (busy !== 1'b0) begin
      $display("FAIL single_idle: busy=%b want 0", busy);
      err++;
    end
  endtask

  task automatic test_rotation;
    bit ok;
    int e;
    do_reset();
    for (int k = 0; k < 10; k++)
      exp_q.push_back((k / 2) % 4);
    ep_dma_req = 4'hF;
    ep_en      = 4'hF;
    for (int k = 0; k < 10; k++) begin
      wait_req(ok);
      e = exp_q.pop_front();
      cmp++;
      if (!ok) begin
        $display("FAIL rot_timeout: beat %0d no req", k);
        err++;
        break;
      end
      if (dma_sel !== 2'(e)) begin
        $display("FAIL rot_sel: beat %0d got %0d want %0d",
                 k, dma_sel, e);
        err++;
      end
      cmp++;
      if (dma_last !== 1'(k % 2)) begin
        $display("FAIL rot_last: beat %0d got %b want %b",
                 k, dma_last, 1'(k % 2));
        err++;
      end
      dma_ack = 1'b1;
      #1;
      cmp++;
      if (ep_dma_ack !== (4'b1 << e)) begin
        $display("FAIL rot_ack: beat %0d got %b want %b",
                 k, ep_dma_ack, 4'b1 << e);
        err++;
      end
      step();
      dma_ack = 1'b0;
      cmp++;
      if (dma_req !== 1'b0) begin
        $display("FAIL rot_hold: beat %0d req=%b want 0",
                 k, dma_req);
        err++;
      end
    end
    exp_q.delete();
    ep_dma_req = '0;
  endtask

  task automatic test_drop;
    bit ok;
    int e;
    do_reset();
    ep_dma_req = 4'b0010;
    ep_en      = 4'hF;
    exp_q.push_back(1);
    exp_q.push_back(3);
    wait_req(ok);
    e = exp_q.pop_front();
    cmp++;
    if (!ok || dma_sel !== 2'(e)) begin
      $display("FAIL drop_grant1: ok=%b sel=%0d want 1 %0d",
               ok, dma_sel, e);
      err++;
    end
    dma_ack = 1'b1;
    step();
    dma_ack    = 1'b0;
    ep_dma_req = 4'b1000;
    cmp++;
    if (dma_req !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL drop_hold: req=%b busy=%b want 0 1",
               dma_req, busy);
      err++;
    end
    step();
    ep_dma_req = 4'b1010;
    cmp++;
    if (busy !== 1'b0) begin
      $display("FAIL drop_idle: busy=%b want 0", busy);
      err++;
    end
    step();
    e = exp_q.pop_front();
    cmp++;
    if (dma_req !== 1'b1 || dma_sel !== 2'(e)) begin
      $display("FAIL drop_grant2: req=%b sel=%0d want 1 %0d",
               dma_req, dma_sel, e);
      err++;
    end
    ep_dma_req = '0;
    dma_ack    = 1'b1;
    step();
    dma_ack = 1'b0;
    step();
  endtask

  task automatic test_masked;
    do_reset();
    ep_en      = 4'b1011;
    ep_dma_req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      step();
      cmp++;
      if (dma_req !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL mask_idle: cyc %0d req=%b busy=%b want 0 0",
                 k, dma_req, busy);
        err++;
      end
    end
    dma_ack = 1'b1;
    #1;
    cmp++;
    if (ep_dma_ack !== 4'b0) begin
      $display("FAIL mask_spur_ack: got %b want 0000", ep_dma_ack);
      err++;
    end
    step();
    dma_ack = 1'b0;
    cmp++;
    if (busy !== 1'b0) begin
      $display("FAIL mask_spur_state: busy=%b want 0", busy);
      err++;
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int e;
    do_reset();
    ep_dma_req = 4'b1000;
    ep_en      = 4'hF;
    wait_req(ok);
    cmp++;
    if (!ok || dma_sel !== 2'd3) begin
      $display("FAIL rmid_grant: ok=%b sel=%0d want 1 3",
               ok, dma_sel);
      err++;
    end
    rst     = 1'b1;
    dma_ack = 1'b1;
    #1;
    cmp++;
    if (ep_dma_ack !== 4'b0) begin
      $display("FAIL rmid_ack: got %b want 0000", ep_dma_ack);
      err++;
    end
    step();
    rst        = 1'b0;
    dma_ack    = 1'b0;
    ep_dma_req = 4'hF;
    cmp++;
    if (dma_req !== 1'b0 || dma_sel !== 2'd0) begin
      $display("FAIL rmid_clear: req=%b sel=%0d want 0 0",
               dma_req, dma_sel);
      err++;
    end
    exp_q.push_back(0);
    step();
    e = exp_q.pop_front();
    cmp++;
    if (dma_req !== 1'b1 || dma_sel !== 2'(e)) begin
      $display("FAIL rmid_restart: req=%b sel=%0d want 1 %0d",
               dma_req, dma_sel, e);
      err++;
    end
    ep_dma_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_drop();
    test_masked();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, err);
    $finish;
  end

endmodule

// File: doc/usbf_dma_arb.md
# usbf_dma_arb

Round-robin DMA request arbiter between the per-endpoint register files and the single external DMA channel of the USB function core. It collects the level `dma_req` outputs of up to `EP_CNT` endpoints and presents one request at a time to the DMA controller, together with the index of the granted endpoint. It returns each `dma_ack` to the owning endpoint and bounds how long one endpoint can hold the channel to `BURST_LEN` transfers.

## Interface
- `EP_CNT`, default 4: number of endpoint requesters; 2..16.
- `SEL_W`, default 2: width of the endpoint index; ceil(log2(EP_CNT)).
- `BURST_LEN`, default 16: maximum acks per grant; 1..255.
- One clock; reset is synchronous and active-high.
- `clk`  in  1: core clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ep_dma_req`  in  EP_CNT: level request from each endpoint register file.
- `ep_en`  in  EP_CNT: per-endpoint enable. A 0 masks that request from arbitration.
- `ep_dma_ack`  out  EP_CNT: one-hot ack pulse routed to the granted endpoint.
- `dma_req`  out  1: request to the DMA controller.
- `dma_sel`  out  SEL_W: index of the granted endpoint; stable while `dma_req` = 1.
- `dma_last`  out  1: high with `dma_req` when the pending beat is the last one the burst allows.
- `dma_ack`  in  1: one-cycle transfer acknowledge from the DMA controller.
- `busy`  out  1: arbiter is not in IDLE.

## Operation
- State register values: IDLE, BUSY, HOLD. Other registers:
  - `ptr` (SEL_W): round-robin start point.
  - `sel` (SEL_W): granted endpoint.
  - `cnt` (8 bits): acks taken in the current grant.
- Reset values:
  - state = IDLE; `ptr` = 0, `sel` = 0, `cnt` = 0.
  - Outputs: `dma_req` = 0, `dma_sel` = 0, `dma_last` = 0, `ep_dma_ack` = 0, `busy` = 0.
- Effective request vector: `vreq = ep_dma_req & ep_en`.
- IDLE:
  - If `vreq` != 0: select the first set bit found searching from `ptr` upward, wrapping past `EP_CNT-1` to 0.
  - Load `sel` with that index, clear `cnt`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `dma_req` = 1 and `dma_sel` = `sel`.
  - On `dma_ack`: assert `ep_dma_ack[sel]` in the same cycle (combinational), increment `cnt`, go to HOLD.
  - Without `dma_ack`: stay in BUSY. An endpoint dropping its request or being disabled does not withdraw a presented request.
- HOLD (one cycle, `dma_req` = 0; gives the endpoint one cycle to deassert its request after the ack):
  - If `vreq[sel]` = 1 and `cnt` < `BURST_LEN`: go to BUSY. `cnt` is kept.
  - Otherwise: `ptr` <= (`sel`+1) mod `EP_CNT`, go to IDLE.
- `dma_last` = `dma_req` & (`cnt` == `BURST_LEN`-1).
- `ep_dma_ack` = `dma_ack` & `dma_req` decoded by `sel`. A `dma_ack` while `dma_req` = 0 is ignored: no pulse, no state change.
- `ptr` wrap: with `sel` = `EP_CNT`-1, the next `ptr` is 0. For non-power-of-two `EP_CNT`, indices ≥ `EP_CNT` are never granted.

## Timing
- Request-to-grant latency: `vreq` seen in IDLE at edge t gives `dma_req` = 1 and valid `dma_sel` from t+1.
- Ack-to-ack spacing within a burst is at least 2 cycles: BUSY → HOLD → BUSY.
- Handover between endpoints: ack at t, HOLD at t+1, IDLE at t+2, next `dma_req` at t+3.
- `dma_sel` changes only on the IDLE→BUSY transition.
- Reset asserted mid-burst: `dma_req` = 0 from the next edge. A `dma_ack` in the reset cycle produces no `ep_dma_ack`, and `ptr` returns to 0.
- Simultaneous requests from all endpoints: each endpoint is granted once per rotation, in index order from `ptr`.
- `cnt` never exceeds `BURST_LEN`; no overflow at `BURST_LEN` = 255.

## Test plan
- Reset, then drive `ep_dma_req` = 4'b0100 with `ep_en` = 4'hF.
  - Required: `dma_req` = 1 and `dma_sel` = 2 one cycle later.
  - Required: `dma_ack` produces `ep_dma_ack` = 4'b0100 in the same cycle.
- Drive all four requests constantly with `BURST_LEN` = 2.
  - Required: grants in order 0,0,1,1,2,2,3,3,0, …
  - Required: `dma_last` is high on every second beat.
- Endpoint 1 drops its request in HOLD after its first ack.
  - Required: IDLE follows, `ptr` = 2, and the next grant goes to endpoint 3 when only endpoints 3 and 1 request.
- `ep_en` = 4'b1011 with `ep_dma_req` = 4'b0100.
  - Required: `dma_req` stays 0 and `busy` stays 0.
  - Required: a spurious `dma_ack` produces no `ep_dma_ack`.
- Assert `rst` while in BUSY with `dma_sel` = 3, with `dma_ack` in the same cycle.
  - Required: no `ep_dma_ack` pulse; `dma_req` = 0 and `dma_sel` = 0 next cycle.
  - Required: after release, grant order restarts from endpoint 0.
